// File: rtl/imem_loadable.sv
// Loadable instruction RAM: sequential load from address 0, 1-cycle registered fetch.
// Fetch is stalled (op=NOP_WORD) while loading; ld_ready is high in LOAD and ERR, so the loader never stalls.
module imem_loadable #(
  parameter int              ADDR_W   = 9,
  parameter int              OP_W     = 23,
  parameter int              DEPTH    = 512,
  parameter logic [OP_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [OP_W-1:0]   op,
  output logic              op_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [OP_W-1:0]   ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              busy,
  output logic              ld_err
);

  typedef enum logic [1:0] {RUN, LOAD, ERR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [OP_W-1:0]   mem [DEPTH];
  logic              xfer;
  logic              wr_en;
  logic              pc_ok;

  // ld_start in LOAD restarts the load and suppresses any write that cycle
  assign xfer  = (state == LOAD) && ld_valid && !ld_start;
  assign wr_en = xfer && !rst;
  assign pc_ok = ({1'b0, pc} < DEPTH_C);

  // Memory is deliberately not reset so a reset mid-load keeps written words
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      ptr      <= '0;
      ld_count <= '0;
      busy     <= 1'b0;
      ld_ready <= 1'b0;
      ld_err   <= 1'b0;
      op       <= NOP_WORD;
      op_valid <= 1'b0;
    end else begin
      case (state)
        RUN, ERR: begin
          if (ld_start) begin
            state    <= LOAD;
            ptr      <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
            busy     <= 1'b1;
            ld_ready <= 1'b1;
            op       <= NOP_WORD;
            op_valid <= 1'b0;
          end else begin
            op_valid <= fetch_en;
            if (fetch_en) op <= pc_ok ? mem[pc] : NOP_WORD;
          end
        end
        LOAD: begin
          op       <= NOP_WORD;
          op_valid <= 1'b0;
          if (ld_start) begin
            ptr      <= '0;
            ld_count <= '0;
          end else if (xfer) begin
            ld_count <= ld_count + CNT_ONE;
            if (ld_last) begin
              state    <= RUN;
              busy     <= 1'b0;
              ld_ready <= 1'b0;
            end else if (ptr == LAST_PTR) begin
              // pointer parks at the last word; ERR then sinks further words
              state  <= ERR;
              busy   <= 1'b0;
              ld_err <= 1'b1;
            end else begin
              ptr <= ptr + PTR_ONE;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench: two DEPTH=4 instances (ADDR_W=3 with out-of-range pcs, ADDR_W=2 full range) against one behavioural model.
module tb_imem_loadable;

  localparam logic [22:0] NOP_A = 23'h5A5A5A;
  localparam logic [22:0] NOP_B = 23'h000000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, fetch_en, ld_start, ld_valid, ld_last;
  logic [2:0]  pc;
  logic [22:0] ld_data;

  logic [22:0] op_a, op_b;
  logic        op_valid_a, op_valid_b, ld_ready_a, ld_ready_b;
  logic        busy_a, busy_b, ld_err_a, ld_err_b;
  logic [3:0]  ld_count_a;
  logic [2:0]  ld_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loadable #(.ADDR_W(3), .OP_W(23), .DEPTH(4), .NOP_WORD(NOP_A)) dut_a (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .op(op_a), .op_valid(op_valid_a),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready_a), .ld_count(ld_count_a), .busy(busy_a), .ld_err(ld_err_a)
  );

  imem_loadable #(.ADDR_W(2), .OP_W(23), .DEPTH(4), .NOP_WORD(NOP_B)) dut_b (
    .clk(clk), .rst(rst), .pc(pc[1:0]), .fetch_en(fetch_en), .op(op_b), .op_valid(op_valid_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready_b), .ld_count(ld_count_b), .busy(busy_b), .ld_err(ld_err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = running, 1 = loading, 2 = overflowed
  int          m_mode, m_count;
  bit          m_err, m_opv, m_opchk, m_live;
  logic [22:0] m_mem [4];
  logic [22:0] m_op_a, m_op_b;

  initial m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_count = 0; m_err = 1'b0;
      m_opv = 1'b0; m_op_a = NOP_A; m_op_b = NOP_B; m_opchk = 1'b1; m_live = 1'b1;
    end else if (m_mode != 1) begin
      if (ld_start) begin
        m_mode = 1; m_count = 0; m_err = 1'b0;
        m_opv = 1'b0; m_op_a = NOP_A; m_op_b = NOP_B; m_opchk = 1'b1;
      end else begin
        m_opv = fetch_en;
        m_opchk = fetch_en;
        if (fetch_en) begin
          m_op_a = (pc < 3'd4) ? m_mem[pc[1:0]] : NOP_A;
          m_op_b = m_mem[pc % 4];
        end
      end
    end else begin
      m_opv = 1'b0; m_op_a = NOP_A; m_op_b = NOP_B; m_opchk = 1'b1;
      if (ld_start) m_count = 0;
      else if (ld_valid) begin
        m_mem[m_count] = ld_data;
        m_count++;
        if (ld_last) m_mode = 0;
        else if (m_count == DEPTH) begin
          m_mode = 2;
          m_err = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("m_busy_a", busy_a, m_mode == 1);
      chk("m_busy_b", busy_b, m_mode == 1);
      chk("m_rdy_a", ld_ready_a, m_mode != 0);
      chk("m_rdy_b", ld_ready_b, m_mode != 0);
      chk("m_err_a", ld_err_a, m_err);
      chk("m_err_b", ld_err_b, m_err);
      chk("m_cnt_a", ld_count_a, m_count);
      chk("m_cnt_b", ld_count_b, m_count);
      chk("m_opv_a", op_valid_a, m_opv);
      chk("m_opv_b", op_valid_b, m_opv);
      if (m_opchk) begin
        chk("m_op_a", op_a, m_op_a);
        chk("m_op_b", op_b, m_op_b);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [22:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic start();
    ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
  endtask

  task automatic fetch(input logic [2:0] a);
    fetch_en = 1'b1; pc = a;
    cyc();
    fetch_en = 1'b0;
  endtask

  logic [22:0] w [3];
  logic [22:0] o [5];

  initial begin
    w = '{23'h0A4000, 23'h100005, 23'h7C00A8};
    o = '{23'h400001, 23'h400002, 23'h400003, 23'h400004, 23'h400005};
    rst = 1'b1; fetch_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    pc = '0; ld_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_opv", op_valid_a, 0);
    chk("rst_cnt", ld_count_a, 0);
    chk("rst_rdy", ld_ready_a, 0);
    chk("rst_err", ld_err_a, 0);
    chk("rst_op", op_a, NOP_A);

    // three-word program, then fetch it back
    start();
    chk("ld_busy", busy_a, 1);
    chk("ld_rdy", ld_ready_a, 1);
    for (int i = 0; i < 3; i++) put(w[i], i == 2);
    chk("ld3_cnt", ld_count_a, 3);
    chk("ld3_busy", busy_a, 0);
    for (int i = 0; i < 3; i++) begin
      fetch(3'(i));
      chk("f_op", op_a, w[i]);
      chk("f_opv", op_valid_a, 1);
    end

    // fetch ignored during load, only valid cycles count
    start();
    fetch_en = 1'b1; pc = 3'd0;
    put(23'h111111, 1'b0);
    chk("tg_cnt1", ld_count_a, 1);
    cyc();
    chk("tg_cnt2", ld_count_a, 1);
    chk("tg_op", op_a, NOP_A);
    chk("tg_opb", op_b, 0);
    chk("tg_opv", op_valid_a, 0);
    chk("tg_busy", busy_a, 1);
    put(23'h222222, 1'b0);
    chk("tg_cnt3", ld_count_a, 2);
    put(23'h333333, 1'b1);
    chk("tg_done", busy_a, 0);
    cyc();
    chk("tg_refetch", op_a, 23'h111111);
    chk("tg_refetchv", op_valid_a, 1);
    fetch_en = 1'b0;

    // overflow into ERR, then sink a fifth word
    start();
    for (int i = 0; i < 4; i++) put(o[i], 1'b0);
    chk("ov_err", ld_err_a, 1);
    chk("ov_cnt", ld_count_a, 4);
    chk("ov_rdy", ld_ready_a, 1);
    chk("ov_busy", busy_a, 0);
    put(o[4], 1'b0);
    chk("ov_sat", ld_count_a, 4);
    chk("ov_rdy2", ld_ready_b, 1);
    fetch(3'd3);
    chk("ov_f3a", op_a, 23'h400004);
    chk("ov_f3b", op_b, 23'h400004);
    fetch(3'd5);
    chk("oor_a", op_a, NOP_A);
    chk("oor_av", op_valid_a, 1);
    chk("oor_b", op_b, 23'h400002);
    start();
    chk("ov_clr", ld_err_a, 0);
    put(23'h0ABCDE, 1'b1);

    // reset part-way through a load
    start();
    put(23'h600001, 1'b0);
    put(23'h600002, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_busy", busy_a, 0);
    chk("mr_opv", op_valid_a, 0);
    chk("mr_cnt", ld_count_a, 0);
    fetch(3'd1);
    chk("mr_f1", op_a, 23'h600002);

    // restart mid-load with ld_valid high on the restart cycle
    start();
    put(23'h700001, 1'b0);
    put(23'h700002, 1'b0);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 23'h7FFFFF;
    cyc();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("rs_cnt0", ld_count_a, 0);
    put(23'h700003, 1'b1);
    chk("rs_cnt1", ld_count_a, 1);
    fetch(3'd0);
    chk("rs_f0", op_a, 23'h700003);
    fetch(3'd1);
    chk("rs_f1", op_a, 23'h700002);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(63) == 0);
      ld_start = ($urandom_range(15) == 0);
      ld_valid = $urandom_range(1);
      ld_last  = ($urandom_range(5) == 0);
      ld_data  = 23'($urandom);
      fetch_en = $urandom_range(1);
      pc       = 3'($urandom_range(7));
      cyc();
    end
    rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; fetch_en = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
